// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//    Takes one 512-bit padded SHA-256 block and streams W[0..63] together with
//    the matching round constant K[round], one word per w_advance. It feeds
//    the compression stage of the round-update datapath.
//
//    Ports
//       clk          system clock, rising edge
//       reset_n      asynchronous active-low reset
//       block_valid  block_data holds a block to load
//       block_data   padded block, W0 in [511:480], W15 in [31:0]
//       block_ready  idle and able to take a block
//       abort        synchronous return to IDLE
//       w_advance    consume the current W/K and step to the next round
//       w_valid      w_data / k_out / round are valid
//       w_data       W[round]
//       k_out        K[round], zero when w_valid is low
//       round        current round index
//       first_round  w_valid and round == 0
//       last_round   w_valid and round == NUM_ROUNDS-1
//       sched_done   one-cycle pulse after the last round is consumed
//
//    state  | meaning
//    IDLE   | waiting for a block, block_ready high
//    ACTIVE | presenting W/K for the current round
//    DONE   | one-cycle completion pulse, nothing accepted

module sha256_msg_schedule #(
   parameter int NUM_ROUNDS = 64,
   parameter int WORD_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  block_valid,
   input  logic [16*WORD_W-1:0]  block_data,
   output logic                  block_ready,
   input  logic                  abort,
   input  logic                  w_advance,
   output logic                  w_valid,
   output logic [WORD_W-1:0]     w_data,
   output logic [WORD_W-1:0]     k_out,
   output logic [$clog2(NUM_ROUNDS)-1:0] round,
   output logic                  first_round,
   output logic                  last_round,
   output logic                  sched_done
);

   localparam int RND_W = $clog2(NUM_ROUNDS);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

   localparam logic [31:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WORD_W-1:0] win [0:15];
   logic [WORD_W-1:0] w_next;
   logic              rnd_last;

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // win[0]=W[t], so W[t+16] needs W[t+14], W[t+9], W[t+1] and W[t].
   assign w_next   = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
   assign rnd_last = (round == LAST_RND);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      block_ready = 1'b0;
      w_valid     = 1'b0;
      sched_done  = 1'b0;
      case (state)
         IDLE: begin
            block_ready = 1'b1;
            if (block_valid) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            w_valid = 1'b1;
            if (w_advance && rnd_last) state_nxt = DONE;
         end
         DONE: begin
            sched_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) win[i] <= '0;
         round <= '0;
      end else if (abort) begin
         round <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (block_valid) begin
                  for (int i = 0; i < 16; i++)
                     win[i] <= block_data[16*WORD_W-1-WORD_W*i -: WORD_W];
                  round <= '0;
               end
            end
            ACTIVE: begin
               if (w_advance) begin
                  if (rnd_last) begin
                     // Window is left as is; round returns to 0 for DONE.
                     round <= '0;
                  end else begin
                     for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                     win[15] <= w_next;
                     round   <= round + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign w_data      = w_valid ? win[0] : '0;
   assign k_out       = w_valid ? K_ROM[round] : '0;
   assign first_round = w_valid && (round == '0);
   assign last_round  = w_valid && rnd_last;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         block_valid;
   logic [511:0] block_data;
   logic         block_ready;
   logic         abort;
   logic         w_advance;
   logic         w_valid;
   logic [31:0]  w_data;
   logic [31:0]  k_out;
   logic [5:0]   round;
   logic         first_round;
   logic         last_round;
   logic         sched_done;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0]  gw [0:63];
   logic [511:0] blk_abc;
   logic [511:0] blk_b;

   sha256_msg_schedule dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .block_valid (block_valid),
      .block_data  (block_data),
      .block_ready (block_ready),
      .abort       (abort),
      .w_advance   (w_advance),
      .w_valid     (w_valid),
      .w_data      (w_data),
      .k_out       (k_out),
      .round       (round),
      .first_round (first_round),
      .last_round  (last_round),
      .sched_done  (sched_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_model(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) gw[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         gw[i] = s1(gw[i-2]) + gw[i-7] + s0(gw[i-15]) + gw[i-16];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_block(input logic [511:0] blk);
      block_data  = blk;
      block_valid = 1'b1;
      step();
      block_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0 || sched_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_held: ready=%b valid=%b done=%b, want 1 0 0",
                  block_ready, w_valid, sched_done);
      end
      reset_n = 1'b1;
      step();
      n_cmp++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0 || round !== 6'd0 ||
          w_data !== 32'h0 || sched_done !== 1'b0 || k_out !== 32'h0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b valid=%b round=%0d w=%h k=%h done=%b, want 1 0 0 0 0 0",
                  block_ready, w_valid, round, w_data, k_out, sched_done);
      end
   endtask

   task automatic test_abc_stream();
      build_model(blk_abc);
      w_advance = 1'b1;
      load_block(blk_abc);
      for (int c = 1; c <= 66; c++) begin
         if (c <= 64) begin
            n_cmp++;
            if (w_valid !== 1'b1 || round !== 6'(c-1) || w_data !== gw[c-1] || sched_done !== 1'b0) begin
               n_err++;
               $display("FAIL abc_w cycle %0d: valid=%b round=%0d w=%h done=%b, want 1 %0d %h 0",
                        c, w_valid, round, w_data, sched_done, c-1, gw[c-1]);
            end
            n_cmp++;
            if (first_round !== (c == 1) || last_round !== (c == 64)) begin
               n_err++;
               $display("FAIL abc_flags cycle %0d: first=%b last=%b, want %b %b",
                        c, first_round, last_round, c == 1, c == 64);
            end
         end
         if (c == 1) begin
            n_cmp++;
            if (w_data !== 32'h61626380 || k_out !== 32'h428a2f98) begin
               n_err++;
               $display("FAIL abc_r0: w=%h k=%h, want 61626380 428a2f98", w_data, k_out);
            end
         end
         if (c == 16) begin
            n_cmp++;
            if (w_data !== 32'h00000018) begin
               n_err++;
               $display("FAIL abc_r15: w=%h, want 00000018", w_data);
            end
         end
         if (c == 17) begin
            n_cmp++;
            if (w_data !== 32'h61626380) begin
               n_err++;
               $display("FAIL abc_r16: w=%h, want 61626380", w_data);
            end
         end
         if (c == 18) begin
            n_cmp++;
            if (w_data !== 32'h000f0000) begin
               n_err++;
               $display("FAIL abc_r17: w=%h, want 000f0000", w_data);
            end
         end
         if (c == 64) begin
            n_cmp++;
            if (k_out !== 32'hc67178f2) begin
               n_err++;
               $display("FAIL abc_r63_k: k=%h, want c67178f2", k_out);
            end
         end
         if (c == 65) begin
            n_cmp++;
            if (sched_done !== 1'b1 || w_valid !== 1'b0 || round !== 6'd0 ||
                block_ready !== 1'b0 || k_out !== 32'h0) begin
               n_err++;
               $display("FAIL abc_done: done=%b valid=%b round=%0d ready=%b k=%h, want 1 0 0 0 0",
                        sched_done, w_valid, round, block_ready, k_out);
            end
         end
         if (c == 66) begin
            n_cmp++;
            if (sched_done !== 1'b0 || block_ready !== 1'b1) begin
               n_err++;
               $display("FAIL abc_idle: done=%b ready=%b, want 0 1", sched_done, block_ready);
            end
         end
         step();
      end
      w_advance = 1'b0;
   endtask

   task automatic test_stall();
      int          exp_rnd;
      bit          done_next;
      bit          finished;
      bit          prev_adv;
      int          done_cnt;
      logic [31:0] prev_w;
      logic [31:0] prev_k;
      build_model(blk_abc);
      w_advance = 1'b0;
      load_block(blk_abc);
      exp_rnd   = 0;
      done_next = 1'b0;
      finished  = 1'b0;
      prev_adv  = 1'b1;
      done_cnt  = 0;
      prev_w    = '0;
      prev_k    = '0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (done_next) begin
            if (sched_done === 1'b1) done_cnt++;
            n_cmp++;
            if (sched_done !== 1'b1 || w_valid !== 1'b0) begin
               n_err++;
               $display("FAIL stall_done: done=%b valid=%b, want 1 0", sched_done, w_valid);
            end
            finished = 1'b1;
            w_advance = 1'b0;
         end else begin
            if (sched_done === 1'b1) done_cnt++;
            n_cmp++;
            if (w_valid !== 1'b1 || round !== 6'(exp_rnd) || w_data !== gw[exp_rnd]) begin
               n_err++;
               $display("FAIL stall_w: valid=%b round=%0d w=%h, want 1 %0d %h",
                        w_valid, round, w_data, exp_rnd, gw[exp_rnd]);
            end
            if (!prev_adv) begin
               n_cmp++;
               if (w_data !== prev_w || k_out !== prev_k) begin
                  n_err++;
                  $display("FAIL stall_hold: w=%h k=%h, want %h %h", w_data, k_out, prev_w, prev_k);
               end
            end
            prev_w    = w_data;
            prev_k    = k_out;
            prev_adv  = 1'($urandom_range(0, 1));
            w_advance = prev_adv;
         end
         step();
         if (!finished && prev_adv) begin
            if (exp_rnd == 63) done_next = 1'b1;
            else exp_rnd++;
         end
      end
      n_cmp++;
      if (!finished) begin
         n_err++;
         $display("FAIL stall_timeout: reached round %0d, want completion", exp_rnd);
      end
      n_cmp++;
      if (done_cnt != 1 || sched_done !== 1'b0 || block_ready !== 1'b1) begin
         n_err++;
         $display("FAIL stall_pulse: pulses=%0d done=%b ready=%b, want 1 0 1",
                  done_cnt, sched_done, block_ready);
      end
   endtask

   task automatic test_back_to_back();
      w_advance   = 1'b1;
      block_data  = blk_abc;
      block_valid = 1'b1;
      step();
      block_data  = blk_b;
      for (int c = 1; c <= 67; c++) begin
         if (c == 2) begin
            n_cmp++;
            if (round !== 6'd1 || w_data !== 32'h00000000) begin
               n_err++;
               $display("FAIL b2b_ignore: round=%0d w=%h, want 1 00000000", round, w_data);
            end
         end
         if (c == 65) begin
            n_cmp++;
            if (sched_done !== 1'b1 || block_ready !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_done: done=%b ready=%b, want 1 0", sched_done, block_ready);
            end
         end
         if (c == 66) begin
            n_cmp++;
            if (block_ready !== 1'b1 || w_valid !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_idle: ready=%b valid=%b, want 1 0", block_ready, w_valid);
            end
         end
         if (c == 67) begin
            n_cmp++;
            if (w_valid !== 1'b1 || round !== 6'd0 || w_data !== 32'h01234567 || first_round !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_second: valid=%b round=%0d w=%h first=%b, want 1 0 01234567 1",
                        w_valid, round, w_data, first_round);
            end
         end
         if (c < 67) step();
      end
      block_valid = 1'b0;
      w_advance   = 1'b0;
      abort       = 1'b1;
      step();
      abort       = 1'b0;
   endtask

   task automatic test_abort();
      w_advance = 1'b1;
      load_block(blk_abc);
      repeat (30) step();
      n_cmp++;
      if (round !== 6'd30) begin
         n_err++;
         $display("FAIL abort_pre: round=%0d, want 30", round);
      end
      abort = 1'b1;
      step();
      n_cmp++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0 || round !== 6'd0 || sched_done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_idle: ready=%b valid=%b round=%0d done=%b, want 1 0 0 0",
                  block_ready, w_valid, round, sched_done);
      end
      block_data  = blk_b;
      block_valid = 1'b1;
      step();
      n_cmp++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0) begin
         n_err++;
         $display("FAIL abort_priority: ready=%b valid=%b, want 1 0", block_ready, w_valid);
      end
      abort       = 1'b0;
      block_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (sched_done !== 1'b0 || w_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_nodone: done=%b valid=%b, want 0 0", sched_done, w_valid);
         end
         step();
      end
      load_block(blk_b);
      n_cmp++;
      if (w_valid !== 1'b1 || round !== 6'd0 || w_data !== 32'h01234567 || first_round !== 1'b1) begin
         n_err++;
         $display("FAIL abort_restart: valid=%b round=%0d w=%h first=%b, want 1 0 01234567 1",
                  w_valid, round, w_data, first_round);
      end
      step();
      n_cmp++;
      if (round !== 6'd1 || w_data !== 32'h89abcdef) begin
         n_err++;
         $display("FAIL abort_restart_r1: round=%0d w=%h, want 1 89abcdef", round, w_data);
      end
      abort = 1'b1;
      step();
      abort     = 1'b0;
      w_advance = 1'b0;
   endtask

   task automatic test_async_reset();
      w_advance = 1'b1;
      load_block(blk_abc);
      repeat (40) step();
      n_cmp++;
      if (round !== 6'd40) begin
         n_err++;
         $display("FAIL areset_pre: round=%0d, want 40", round);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0 || round !== 6'd0 || w_data !== 32'h0 ||
          k_out !== 32'h0 || sched_done !== 1'b0) begin
         n_err++;
         $display("FAIL areset_now: ready=%b valid=%b round=%0d w=%h k=%h done=%b, want 1 0 0 0 0 0",
                  block_ready, w_valid, round, w_data, k_out, sched_done);
      end
      w_advance = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      n_cmp++;
      if (block_ready !== 1'b1 || w_valid !== 1'b0) begin
         n_err++;
         $display("FAIL areset_after: ready=%b valid=%b, want 1 0", block_ready, w_valid);
      end
   endtask

   initial begin
      blk_abc     = {32'h61626380, 448'h0, 32'h00000018};
      blk_b       = {32'h01234567, 32'h89abcdef, 384'h0, 32'hcafef00d, 32'h00000200};
      reset_n     = 1'b0;
      block_valid = 1'b0;
      block_data  = '0;
      abort       = 1'b0;
      w_advance   = 1'b0;
      #3;
      test_reset();
      test_abc_stream();
      test_stall();
      test_back_to_back();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
